// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC, a one-entry prefetch buffer and IR, and fetches over a req/ack handshake.
// Optional build macro FETCH_PROTO_CHECK_EN adds a sticky protocol-error flag on err.
module instr_fetch_unit #(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loadIR,
  input  logic              incPC,
  input  logic              loadPC,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              en,
  output logic [3:0]        opcode,
  output logic [15:0]       ir,
  output logic [ADDR_W-1:0] pc,
  output logic              err
);

  // Handshake: a read transfers on a rising edge where imem_req and imem_ack are both 1;
  // imem_addr holds while imem_req is 1, and a new request may start on the transfer edge.
  typedef enum logic [1:0] {IDLE, REQ, HOLD, EXEC} stateT;

  stateT             state;
  logic [15:0]       buffer;
  logic              stale;
  logic              pcUpd;
  logic [ADDR_W-1:0] nextPc;

  assign pcUpd  = loadPC | incPC;
  assign opcode = ir[15:12];

  always_comb begin
    nextPc = pc;
    if (loadPC)     nextPc = jump_addr;
    else if (incPC) nextPc = pc + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      buffer    <= '0;
      stale     <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      en        <= 1'b0;
    end else begin
      pc <= nextPc;
      case (state)
        IDLE: begin
          state     <= REQ;
          imem_addr <= nextPc;
          imem_req  <= 1'b1;
          stale     <= 1'b0;
        end
        REQ: begin
          if (imem_req && imem_ack) begin
            // Data fetched for an outdated PC is dropped and the fetch restarts at the new PC.
            if (stale || pcUpd) begin
              stale     <= 1'b0;
              imem_addr <= nextPc;
              imem_req  <= 1'b1;
            end else begin
              buffer   <= imem_rdata;
              imem_req <= 1'b0;
              en       <= 1'b1;
              state    <= HOLD;
            end
          end else if (pcUpd) begin
            stale <= 1'b1;
          end
        end
        HOLD: begin
          if (loadIR) ir <= buffer;
          if (pcUpd) begin
            state     <= REQ;
            en        <= 1'b0;
            imem_addr <= nextPc;
            imem_req  <= 1'b1;
            stale     <= 1'b0;
          end else if (loadIR) begin
            state <= EXEC;
            en    <= 1'b0;
          end
        end
        EXEC: begin
          if (pcUpd) begin
            state     <= REQ;
            imem_addr <= nextPc;
            imem_req  <= 1'b1;
            stale     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PROTO_CHECK_EN
  logic errFlag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errFlag <= 1'b0;
    end else if ((loadIR && state != HOLD) || (incPC && loadPC) || (imem_ack && !imem_req)) begin
      errFlag <= 1'b1;
    end
  end

  assign err = errFlag;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Responder side of the controller's fetch strobes (`loadIR`, `loadPC`, `incPC`) in the 16-bit RISC core.
- Owns the PC, a one-entry prefetch buffer and the IR; fetches instruction words from instruction memory over a req/ack handshake.
- Presents `opcode` and an instruction-available `en` to `controller`.
- Applies PC increment and jump updates issued by `controller`.

## Interface
Parameters:
- `ADDR_W`, 8, PC / instruction-memory address width
- `RESET_PC`, 0, PC value loaded on reset

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `loadIR`  in  1  from controller: move prefetch buffer into IR
- `incPC`  in  1  from controller: PC <= PC+1
- `loadPC`  in  1  from controller: PC <= `jump_addr`
- `jump_addr`  in  ADDR_W  jump target from datapath
- `imem_req`  out  1  instruction-memory read request
- `imem_addr`  out  ADDR_W  read address, stable while `imem_req`=1
- `imem_ack`  in  1  read data valid; sampled only while `imem_req`=1
- `imem_rdata`  in  16  instruction word
- `en`  out  1  prefetch buffer holds a valid, non-stale instruction
- `opcode`  out  4  `ir[15:12]`
- `ir`  out  16  current instruction register
- `pc`  out  ADDR_W  current program counter
- `err`  out  1  sticky protocol-error flag (see Configuration)

## Operation
- States: IDLE, REQ, HOLD, EXEC.
- Reset values:
  - state=IDLE, `pc`=RESET_PC, `ir`=0, buffer=0
  - `imem_req`=0, `imem_addr`=0, `en`=0, `err`=0
- IDLE -> REQ unconditionally on the next edge.
  - On that edge `imem_addr`<=`pc` and `imem_req`<=1.
- REQ, on `imem_ack`=1:
  - buffer<=`imem_rdata`, `imem_req`<=0.
  - Next state is HOLD, unless the PC changed during the request (stale flag set): data is discarded and the unit re-enters REQ with the new `pc`.
- HOLD: `en`=1. On `loadIR`: `ir`<=buffer, go to EXEC.
- EXEC, on `loadPC` or `incPC`: update PC, go to REQ, latch `imem_addr`<=new PC.
- PC update rules, in any state:
  - `loadPC` has priority over `incPC`.
  - `incPC` wraps modulo 2^ADDR_W (e.g. 8'hFF -> 8'h00).
- PC update in HOLD:
  - buffer is stale; state returns to REQ with the new PC and `en` drops.
  - A simultaneous `loadIR` still loads the old buffer into IR, but the next state is REQ, not EXEC.
- PC update in REQ:
  - sets the stale flag; the in-flight request completes at the old `imem_addr`.
  - a PC update on the same edge as `imem_ack` also counts as stale.
- `loadIR` outside HOLD: ignored; IR unchanged.
- `rst` mid-request: `imem_req` drops asynchronously and the request is abandoned. Instruction memory tolerates a dropped `req`.

## Timing
- All state and outputs are registered.
- `en`, `opcode`, `ir`, `pc` change only on rising `clk`, except async reset.
- Fetch latency is 1 + N cycles from entering REQ, where N is the number of cycles until `imem_ack`.
  - Minimum: ack in the first REQ cycle gives `en`=1 at the next edge.
- `loadIR` is sampled at the edge; `opcode` reflects the new IR in the following cycle.
- First instruction after reset release: `imem_req` rises at edge 1, with the earliest `en` at edge 2.
- `imem_addr` never changes while `imem_req`=1.

## Configuration
- `FETCH_PROTO_CHECK_EN` defined:
  - `err` is set, and held until `rst`, on:
    - `loadIR` outside HOLD;
    - `incPC` and `loadPC` high on the same edge;
    - `imem_ack` while `imem_req`=0.
  - Behaviour is otherwise identical.
- Not defined: `err` is tied to 0 and no checking logic is built.

## Test plan
- Reset, memory acks in 1 cycle with word 16'h9123 at addr 0:
  - `imem_req` at edge 1, `en`=1 at edge 2;
  - `loadIR` -> `ir`=16'h9123, `opcode`=4'b1001.
- `incPC` in EXEC with `pc`=8'hFF -> `pc`=8'h00, `imem_addr`=8'h00, `imem_req`=1.
- `loadPC` with `jump_addr`=8'h40 during a 3-cycle-latency fetch at addr 5:
  - ack data dropped, `en` stays 0;
  - re-request at 8'h40; its data reaches IR on `loadIR`.
- `loadPC` and `incPC` together, `jump_addr`=8'h10 -> `pc`=8'h10.
  - `err`=1 only with FETCH_PROTO_CHECK_EN.
- `loadIR` pulsed in REQ -> `ir` unchanged, `en`=0.
- Assert `rst` while `imem_req`=1 -> `imem_req`=0 and `pc`=RESET_PC immediately, before the next edge.
